// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The slave side is the adder; the master side is whoever feeds it and drains it.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
) ();
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic             sub_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] out_o;
  logic             cout_o;
  logic             ovf_o;

  modport slave (
    input  valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    output ready_o, valid_o, out_o, cout_o, ovf_o
  );

  modport master (
    output valid_i, a_i, b_i, cin_i, sub_i, ready_i,
    input  ready_o, valid_o, out_o, cout_o, ovf_o
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Carry-chunked pipelined adder/subtractor: one CHUNK-bit slice resolved per stage,
// carry ripples one slice per cycle, one operation per clock with global backpressure.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  pipelined_addsub_if.slave bus
);
  localparam int NUM_CHUNKS = (CHUNK > 0) ? WIDTH / CHUNK : 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  // Per-stage registers. Operand bits above the current slice form the input skew;
  // result bits below it form the output de-skew. Unread bits are left to synthesis.
  logic [WIDTH-1:0]      a_q   [NUM_CHUNKS];
  logic [WIDTH-1:0]      b_q   [NUM_CHUNKS];
  logic [WIDTH-1:0]      sum_q [NUM_CHUNKS];
  logic [NUM_CHUNKS-1:0] c_q;
  logic [NUM_CHUNKS-1:0] sub_q;
  logic [NUM_CHUNKS-1:0] vld_q;
  logic                  ovf_q;

  logic [WIDTH-1:0]      a_in   [NUM_CHUNKS];
  logic [WIDTH-1:0]      b_in   [NUM_CHUNKS];
  logic [WIDTH-1:0]      sum_in [NUM_CHUNKS];
  logic [WIDTH-1:0]      sum_nx [NUM_CHUNKS];
  logic [NUM_CHUNKS-1:0] c_in;
  logic [NUM_CHUNKS-1:0] sub_in;
  logic [NUM_CHUNKS-1:0] vld_in;
  logic [NUM_CHUNKS-1:0] c_nx;
  logic [CHUNK:0]        slice;
  logic                  ovf_nx;
  logic                  adv;

  assign adv         = bus.ready_i | ~vld_q[NUM_CHUNKS-1];
  assign bus.ready_o = adv;
  assign bus.valid_o = vld_q[NUM_CHUNKS-1];
  assign bus.out_o   = sum_q[NUM_CHUNKS-1];
  assign bus.cout_o  = sub_q[NUM_CHUNKS-1] ^ c_q[NUM_CHUNKS-1];
  assign bus.ovf_o   = ovf_q;

  // Subtraction is folded into stage 0 as a + ~b + ~cin, so every later stage is a plain add.
  always_comb begin
    c_in   = '0;
    sub_in = '0;
    vld_in = '0;
    c_nx   = '0;
    slice  = '0;
    ovf_nx = 1'b0;

    a_in[0]   = bus.a_i;
    b_in[0]   = bus.sub_i ? ~bus.b_i : bus.b_i;
    sum_in[0] = '0;
    c_in[0]   = bus.sub_i ^ bus.cin_i;
    sub_in[0] = bus.sub_i;
    vld_in[0] = bus.valid_i;
    for (int j = 1; j < NUM_CHUNKS; j++) begin
      a_in[j]   = a_q[j-1];
      b_in[j]   = b_q[j-1];
      sum_in[j] = sum_q[j-1];
      c_in[j]   = c_q[j-1];
      sub_in[j] = sub_q[j-1];
      vld_in[j] = vld_q[j-1];
    end

    for (int j = 0; j < NUM_CHUNKS; j++) begin
      slice = {1'b0, a_in[j][j*CHUNK +: CHUNK]}
            + {1'b0, b_in[j][j*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, c_in[j]};
      c_nx[j]                     = slice[CHUNK];
      sum_nx[j]                   = sum_in[j];
      sum_nx[j][j*CHUNK +: CHUNK] = slice[CHUNK-1:0];
      // Same-sign operands producing a different-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
      if (j == NUM_CHUNKS - 1) begin
        ovf_nx = (a_in[j][WIDTH-1] == b_in[j][WIDTH-1]) && (slice[CHUNK-1] != a_in[j][WIDTH-1]);
      end
    end
  end

  // All stages share one advance enable, so a stalled output freezes the whole pipe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int j = 0; j < NUM_CHUNKS; j++) begin
        a_q[j]   <= '0;
        b_q[j]   <= '0;
        sum_q[j] <= '0;
      end
      c_q   <= '0;
      sub_q <= '0;
      vld_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int j = 0; j < NUM_CHUNKS; j++) begin
        a_q[j]   <= a_in[j];
        b_q[j]   <= b_in[j];
        sum_q[j] <= sum_nx[j];
      end
      c_q   <= c_nx;
      sub_q <= sub_in;
      vld_q <= vld_in;
      ovf_q <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: one backpressured CHUNK=8 instance plus
// CHUNK=32 and CHUNK=4 instances that accept exactly the same operation stream.
module tb_pipelined_addsub;
  typedef struct packed {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] out;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC] = '{
    '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0},
    '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0},
    '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1},
    '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
    '{32'h00FF00FF, 32'h00FF00FF, 1'b1, 1'b0, 32'h01FE01FF, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1},
    '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0},
    '{32'h00000010, 32'h00000010, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0},
    '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0},
    '{32'h00000100, 32'h00000001, 1'b1, 1'b1, 32'h000000FE, 1'b0, 1'b0},
    '{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0},
    '{32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 32'h0001FFFE, 1'b0, 1'b0}
  };

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   rand_ready = 1'b0;
  exp_t sb_q [3][$];

  pipelined_addsub_if #(.WIDTH(32)) bus8 ();
  pipelined_addsub_if #(.WIDTH(32)) bus32 ();
  pipelined_addsub_if #(.WIDTH(32)) bus4 ();

  pipelined_addsub #(.WIDTH(32), .CHUNK(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));
  pipelined_addsub #(.WIDTH(32), .CHUNK(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  pipelined_addsub #(.WIDTH(32), .CHUNK(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(bus4));

  // Side instances never stall and only see an op when the main instance accepts it.
  assign bus32.valid_i = bus8.valid_i & bus8.ready_o;
  assign bus32.a_i     = bus8.a_i;
  assign bus32.b_i     = bus8.b_i;
  assign bus32.cin_i   = bus8.cin_i;
  assign bus32.sub_i   = bus8.sub_i;
  assign bus32.ready_i = 1'b1;
  assign bus4.valid_i  = bus8.valid_i & bus8.ready_o;
  assign bus4.a_i      = bus8.a_i;
  assign bus4.b_i      = bus8.b_i;
  assign bus4.cin_i    = bus8.cin_i;
  assign bus4.sub_i    = bus8.sub_i;
  assign bus4.ready_i  = 1'b1;

  logic [2:0]  vo, co, fo, ri;
  logic [31:0] ov [3];
  assign vo = {bus4.valid_o, bus32.valid_o, bus8.valid_o};
  assign co = {bus4.cout_o, bus32.cout_o, bus8.cout_o};
  assign fo = {bus4.ovf_o, bus32.ovf_o, bus8.ovf_o};
  assign ri = {bus4.ready_i, bus32.ready_i, bus8.ready_i};
  assign ov[0] = bus8.out_o;
  assign ov[1] = bus32.out_o;
  assign ov[2] = bus4.out_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    logic [32:0] r;
    exp_t        e;
    if (!sub) begin
      r     = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      e.ovf = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r     = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      e.ovf = (a[31] != b[31]) && (r[31] != a[31]);
    end
    e.out  = r[31:0];
    e.cout = r[32];
    return e;
  endfunction

  task automatic checkOutput(input string name, input int d, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut=%0d actual out=%h cout=%b ovf=%b required out=%h cout=%b ovf=%b",
               name, d, act.out, act.cout, act.ovf, exp.out, exp.cout, exp.ovf);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the op was accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic cin,
                               input logic sub, input exp_t e, output int waited);
    waited       = 0;
    bus8.a_i     = a;
    bus8.b_i     = b;
    bus8.cin_i   = cin;
    bus8.sub_i   = sub;
    bus8.valid_i = 1'b1;
    forever begin
      bus8.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (bus8.ready_o) begin
        for (int d = 0; d < 3; d++) sb_q[d].push_back(e);
        @(posedge clk);
        #1;
        return;
      end
      waited++;
      if (waited > 200) begin
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout actual ready_o=0 for %0d cycles required=accept", waited);
        bus8.valid_i = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleCycles(input int n);
    bus8.valid_i = 1'b0;
    repeat (n) begin
      bus8.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyVec(input int i);
    int w;
    applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                  '{out: vecs[i].out, cout: vecs[i].cout, ovf: vecs[i].ovf}, w);
  endtask

  // Junk is presented while stalled; it must never be accepted.
  task automatic stallCycles(input int n);
    bus8.a_i     = 32'hDEADBEEF;
    bus8.b_i     = 32'h0BADF00D;
    bus8.valid_i = 1'b1;
    bus8.ready_i = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if (bus8.ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_ready actual=%b required=0", bus8.ready_o);
      end
      @(posedge clk);
      #1;
    end
    bus8.ready_i = 1'b1;
  endtask

  task automatic drainAll();
    int n = 0;
    bus8.valid_i = 1'b0;
    bus8.ready_i = 1'b1;
    while ((sb_q[0].size() + sb_q[1].size() + sb_q[2].size()) != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (sb_q[d].size() != 0) begin
        errors++;
        $display("[TB] FAIL drain dut=%0d actual pending=%0d required=0", d, sb_q[d].size());
      end
    end
  endtask

  exp_t mon_exp, mon_act, prev_res;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      mon_act = '{out: ov[0], cout: co[0], ovf: fo[0]};
      if (prev_stall) begin
        checkOutput("stall_hold", 0, mon_act, prev_res);
        checks++;
        if (vo[0] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stall_valid actual=%b required=1", vo[0]);
        end
      end
      prev_stall = vo[0] & ~ri[0];
      prev_res   = mon_act;
      for (int d = 0; d < 3; d++) begin
        if (vo[d] && ri[d]) begin
          if (sb_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result dut=%0d actual out=%h required=no result", d, ov[d]);
          end else begin
            mon_exp = sb_q[d].pop_front();
            checkOutput("result", d, '{out: ov[d], cout: co[d], ovf: fo[d]}, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    int          stall_sum;
    int          w;
    logic [31:0] ra, rb;
    logic        rc, rs;
    logic [2:0]  seen;

    rst          = 1'b1;
    bus8.valid_i = 1'b0;
    bus8.ready_i = 1'b1;
    bus8.a_i     = '0;
    bus8.b_i     = '0;
    bus8.cin_i   = 1'b0;
    bus8.sub_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_state", d, '{out: ov[d], cout: co[d], ovf: fo[d]}, '0);
      checks++;
      if (vo[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_valid dut=%0d actual=%b required=0", d, vo[d]);
      end
    end
    checks++;
    if (bus8.ready_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready actual=%b required=1", bus8.ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < NVEC; i++) applyVec(i);
    drainAll();

    $display("[TB] full pipeline stall");
    for (int i = 3; i < 7; i++) applyVec(i);
    stallCycles(5);
    for (int i = 7; i < 10; i++) applyVec(i);
    drainAll();

    $display("[TB] back-to-back mixed stream");
    stall_sum = 0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      stall_sum += w;
    end
    checks++;
    if (stall_sum != 0) begin
      errors++;
      $display("[TB] FAIL no_bubbles actual stalls=%0d required=0", stall_sum);
    end
    drainAll();

    $display("[TB] random backpressure stream");
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, rs, model(ra, rb, rc, rs), w);
      if ($urandom_range(0, 7) == 0) idleCycles(1);
    end
    rand_ready = 1'b0;
    drainAll();

    $display("[TB] reset with ops in flight");
    for (int i = 0; i < 3; i++) applyVec(i);
    bus8.valid_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput("reset_flush", d, '{out: ov[d], cout: co[d], ovf: fo[d]}, '0);
      checks++;
      if (vo[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_flush_valid dut=%0d actual=%b required=0", d, vo[d]);
      end
      sb_q[d].delete();
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = '0;
    repeat (10) begin
      @(negedge clk);
      seen |= vo;
    end
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (seen[d] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_quiet dut=%0d actual valid seen=1 required=0", d);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 9; i < NVEC; i++) applyVec(i);
    drainAll();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Next-generation pipelined carry-chunked adder/subtractor.
- Splits a WIDTH-bit operation into CHUNK-bit slices. Each slice occupies one pipeline stage, and the carry ripples one slice per cycle.
- Inputs are skewed and outputs are de-skewed, so throughput is one operation per clock.
- Adds a valid/ready handshake with full-pipeline backpressure, a per-operation add/subtract select, signed overflow detection and an asynchronous reset.
- Used as the arithmetic datapath primitive wherever a wide add must close timing at high clock rates.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a positive multiple of CHUNK (elaboration error otherwise).
- CHUNK, 8, bits resolved per pipeline stage; 1 <= CHUNK <= WIDTH.
- NUM_CHUNKS, WIDTH/CHUNK, derived localparam; equals pipeline latency in cycles.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  asynchronous active-high reset.
- valid_i  input  1  operation presented on a_i/b_i/cin_i/sub_i.
- ready_o  output  1  block accepts an operation this cycle.
- a_i  input  WIDTH  operand A (unsigned or two's complement).
- b_i  input  WIDTH  operand B.
- cin_i  input  1  carry-in (add) / borrow-in (subtract).
- sub_i  input  1  0: out = a + b + cin; 1: out = a - b - cin.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- out_o  output  WIDTH  result, modulo 2^WIDTH.
- cout_o  output  1  add: carry-out; subtract: borrow-out (1 when a < b + cin, unsigned).
- ovf_o  output  1  signed two's-complement overflow of the operation.

Behaviour:
- Reset (async assert, sync release): every pipeline register, skew register and valid bit clears. valid_o=0, out_o=0, cout_o=0, ovf_o=0, ready_o=1.
- Handshake
  - Global advance enable: adv = ready_i | ~valid_o; ready_o = adv.
  - Input accepted when valid_i & ready_o.
  - Result transferred when valid_o & ready_i.
- Stall (adv=0)
  - Every register, including skew, carry and valid, holds its value.
  - Inputs are ignored.
  - out_o, cout_o and ovf_o stay stable while valid_o=1 and ready_i=0.
- Bubbles: when adv=1 with valid_i=0, a 0 valid bit enters the pipeline. Data registers may load don't-care values, but outputs are only defined while valid_o=1.
- Latency: exactly NUM_CHUNKS advancing cycles from acceptance to valid_o. Results emerge in acceptance order. With ready_i held high, an op accepted at edge k appears after edge k+NUM_CHUNKS-1 (visible in cycle k+NUM_CHUNKS-1..k+NUM_CHUNKS window per stage count).
- Subtract
  - Effective B = sub ? ~b : b; effective carry-in = sub ? ~cin_i : cin_i.
  - sub_i is captured with its operation and travels with it. Mixed add/sub streams are legal back-to-back.
- Stage j (0..NUM_CHUNKS-1)
  - Adds slice j of the skewed A and effective B plus the carry registered from stage j-1 (stage 0 uses the effective carry-in).
  - Registers a CHUNK-bit sum and a carry.
  - Slice j operands are delayed j stages on input; the slice j sum is delayed NUM_CHUNKS-1-j stages on output. All delay lines share adv.
- Final stage
  - cout_o = sub ? ~carry_out : carry_out.
  - ovf_o = carry into MSB XOR carry out of MSB, computed inside the top slice.
- Degenerate NUM_CHUNKS=1: single registered stage, latency 1, no skew registers.
- Reset mid-operation discards all in-flight results; no valid_o pulse occurs until new ops are accepted.
- Simultaneous accept and drain (full pipeline, ready_i=1, valid_i=1) sustains 100% throughput.

Test Plan:
- WIDTH=32, CHUNK=8, ready_i=1: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> after 4 cycles valid_o=1, out_o=0x00000000, cout_o=1, ovf_o=0.
- Subtract: a=0x00000005, b=0x00000007, cin=0, sub=1 -> out_o=0xFFFFFFFE, cout_o=1 (borrow), ovf_o=0. Then a=0x80000000, b=1, sub=1 -> out_o=0x7FFFFFFF, cout_o=0, ovf_o=1.
- Signed add overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> out_o=0x80000000, ovf_o=1, cout_o=0. With cin=1 and a=b=0x00FF00FF -> out_o=0x01FE01FF.
- Back-to-back stream: 100 random mixed add/sub ops with valid_i continuously high -> one result per cycle, in order, all matching the reference model, with no bubbles.
- Backpressure: fill the pipeline, drop ready_i for 5 cycles -> ready_o=0, out_o/valid_o stable, no op lost or duplicated. Random ready_i/valid_i toggling over 1000 ops -> scoreboard exact match.
- Reset: assert rst_i asynchronously (between edges) with 3 ops in flight -> outputs zero immediately, valid_o stays 0 after release until a new op completes. Also repeat the first three scenarios with CHUNK=32 (latency 1) and CHUNK=4 (latency 8).
